// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and op-classification helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV)  || (f == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic wants_high(input logic [2:0] f);
        return !f[2] && (f != OP_MUL);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the Execute stage and muldiv_unit.
// master: start, flush, funct3, a, b out; busy, done, result in.
interface muldiv_if #(
    parameter int XLEN = 32
) ();

    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_seq.sv
// Iteration engine: shift-add multiply / restoring divide, one bit per step.
// Ports: clk, reset; init_i loads opa_i/opb_i magnitudes, step_i advances one
// bit, div_i selects divide; last_o flags the final step; prod_o, quot_o,
// rem_o give the values the registers take after the current step.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quot_o,
    output logic [XLEN-1:0]   rem_o
);

    localparam int CW = $clog2(XLEN);

    // acc_q: {high partial product, multiplier} or {unused, dividend/quotient}
    // dvs_q: multiplicand or divisor
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;

    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mul_nx;
    logic [XLEN:0]     shl;
    logic [XLEN:0]     trial;
    logic              qbit;
    logic [XLEN:0]     rem_nx;
    logic [XLEN-1:0]   quot_nx;

    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_nx  = {sum, acc_q[XLEN-1:1]};
        shl     = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        trial   = shl - {1'b0, dvs_q};
        // A borrow into the extra bit means the subtract must be undone.
        qbit    = ~trial[XLEN];
        rem_nx  = qbit ? trial : shl;
        quot_nx = {acc_q[XLEN-2:0], qbit};
    end

    assign last_o = (cnt_q == '0);
    assign prod_o = mul_nx;
    assign quot_o = quot_nx;
    assign rem_o  = rem_nx[XLEN-1:0];

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (init_i) begin
            cnt_d = CW'(XLEN - 1);
            acc_d = div_i ? {{XLEN{1'b0}}, opa_i} : {{XLEN{1'b0}}, opb_i};
            dvs_d = div_i ? opb_i : opa_i;
            rem_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q - CW'(1);
            if (div_i) begin
                acc_d = {acc_q[2*XLEN-1:XLEN], quot_nx};
                rem_d = rem_nx;
            end else begin
                acc_d = mul_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Ports: clk, reset (async, active-high); bus (slave) carries start, flush,
// funct3, a, b in and busy, done, result out.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              init, step, last;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   fin_val;

    // Operand magnitudes; the most negative value negates to itself and
    // is then read as an unsigned magnitude.
    always_comb begin
        sa    = is_signed_a(op_q) & a_q[XLEN-1];
        sb    = is_signed_b(op_q) & b_q[XLEN-1];
        mag_a = sa ? -a_q : a_q;
        mag_b = sb ? -b_q : b_q;
    end

    muldiv_seq #(.XLEN(XLEN)) u_seq (
        .clk    (clk),
        .reset  (reset),
        .init_i (init),
        .step_i (step),
        .div_i  (is_div(op_q)),
        .opa_i  (mag_a),
        .opb_i  (mag_b),
        .last_o (last),
        .prod_o (prod),
        .quot_o (quot),
        .rem_o  (rem)
    );

    // Sign fix and special cases, evaluated on the final step's values.
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        if (!is_div(op_q)) begin
            fin_val = wants_high(op_q) ? prod_s[2*XLEN-1:XLEN]
                                       : prod_s[XLEN-1:0];
        end else if (is_rem(op_q)) begin
            fin_val = dz_q  ? a_q :
                      ovf_q ? '0  :
                      neg_q ? -rem : rem;
        end else begin
            fin_val = dz_q  ? '1  :
                      ovf_q ? a_q :
                      neg_q ? -quot : quot;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        res_d    = res_q;
        result_d = result_q;
        init     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = PREP;
                    op_d    = bus.funct3;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
            end
            PREP: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                    init    = 1'b1;
                    dz_d    = (b_q == '0);
                    ovf_d   = is_div(op_q) && is_signed_b(op_q) &&
                              (a_q == MIN_NEG) && (b_q == '1);
                    if (!is_div(op_q)) begin
                        neg_d = sa ^ sb;
                    end else if (is_rem(op_q)) begin
                        neg_d = sa;
                    end else begin
                        neg_d = (sa ^ sb) && (b_q != '0);
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_d = FIN;
                        res_d   = fin_val;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                // Commit only if not squashed, so a flush leaves result as-is.
                if (!bus.flush) begin
                    result_d = res_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            res_q    <= res_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == FIN) && !bus.flush;
    assign bus.result = (state_q == FIN) ? res_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): latency, ops, special cases,
// flush, ignored starts and asynchronous reset.
module tb_muldiv_unit;

    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start at edge N; cycle c is the period after edge N+c-1.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp);
        int dc;
        int np;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = av;
        bus.b      = bv;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dc = 0;
        np = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
            if (c == 35) chk({tag, "_busy35"}, 32'(bus.busy), 32'd0);
            if (bus.done) begin
                np++;
                if (dc == 0) dc = c;
                chk({tag, "_res"}, bus.result, exp);
            end
        end
        chk({tag, "_donecyc"}, 32'(dc), 32'd34);
        chk({tag, "_npulse"}, 32'(np), 32'd1);
        chk({tag, "_held"}, bus.result, exp);
    endtask

    initial begin
        int np;
        int dc;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a      = '0;
        bus.b      = '0;

        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulh",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhu",    OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhsu",   OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000);
        run_op("mulhu_ff", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("div_ovf",  OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf",  OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_op("divu_z",   OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("remu_z",   OP_REMU,   32'd5,        32'd0,        32'd5);
        run_op("div_neg",  OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("rem_neg",  OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("remu",     OP_REMU,   32'd100,      32'd7,        32'd2);
        run_op("divu",     OP_DIVU,   32'd100,      32'd7,        32'd14);

        // Flush in cycle 10 of a DIV, then restart in cycle 12.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OP_DIV;
        bus.a      = 32'd1000;
        bus.b      = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        np = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) np++;
            if (c == 10) bus.flush = 1'b1;
        end
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_done", 32'(bus.done), 32'd0);
        chk("flush_npulse", 32'(np), 32'd0);
        chk("flush_result", bus.result, 32'd14);
        run_op("restart", OP_DIV, 32'd1000, 32'd3, 32'd333);

        // start together with flush in IDLE is dropped.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = OP_MUL;
        bus.a      = 32'd2;
        bus.b      = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("sflush_busy", 32'(bus.busy), 32'd0);
        chk("sflush_result", bus.result, 32'd333);

        // Extra starts during RUN and during FIN are ignored.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OP_MUL;
        bus.a      = 32'd3;
        bus.b      = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        np = 0;
        dc = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (bus.done) begin
                np++;
                if (dc == 0) dc = c;
            end
            if (c == 35) chk("ign_busy35", 32'(bus.busy), 32'd0);
            if (c == 36) chk("ign_busy36", 32'(bus.busy), 32'd0);
            if (c == 10 || c == 34) begin
                bus.start  = 1'b1;
                bus.funct3 = OP_MULHU;
                bus.a      = 32'hFFFFFFFF;
                bus.b      = 32'hFFFFFFFF;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("ign_donecyc", 32'(dc), 32'd34);
        chk("ign_npulse", 32'(np), 32'd1);
        chk("ign_result", bus.result, 32'd15);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = OP_MUL;
        bus.a      = 32'd7;
        bus.b      = 32'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        np = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) np++;
        end
        chk("arst_npulse", 32'(np), 32'd0);
        chk("arst_hold", bus.result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
